// File: rtl/free_list.sv
// Circular free list of physical-register tags with head checkpoint/rollback.
// Optional FREE_LIST_BYPASS_EN: an empty-list allocate may take the tag freed in the same cycle.
module free_list #(
  parameter int NUM_PR = 64,
  parameter int NUM_AR = 32,
  parameter int NUM_FL = NUM_PR - NUM_AR,
  parameter int PRW    = $clog2(NUM_PR),
  parameter int PW     = $clog2(NUM_FL) + 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           en,
  input  logic           dispatch_en,
  output logic [PRW-1:0] T_out,
  output logic           alloc_valid,
  input  logic           free_en,
  input  logic [PRW-1:0] T_old_in,
  input  logic           checkpoint_en,
  input  logic           rollback_en,
  output logic           empty,
  output logic           full,
  output logic [PW-1:0]  free_count,
  output logic           overflow_err
);

  localparam int IW = PW - 1;

  logic [PRW-1:0] entry_reg [NUM_FL];
  logic [PW-1:0]  head_reg, head_next;
  logic [PW-1:0]  tail_reg, tail_next;
  logic [PW-1:0]  ckpt_head_reg, ckpt_head_next;
  logic           overflow_err_reg;
  logic           alloc_fire, free_fire, bypass_fire;
  logic [IW-1:0]  head_idx, tail_idx;

  assign head_idx = head_reg[IW-1:0];
  assign tail_idx = tail_reg[IW-1:0];

  assign empty = (head_reg == tail_reg);
  assign full  = (head_idx == tail_idx) && (head_reg[PW-1] != tail_reg[PW-1]);

`ifdef FREE_LIST_BYPASS_EN
  assign bypass_fire = en && dispatch_en && free_en && empty && !rollback_en;
`else
  assign bypass_fire = 1'b0;
`endif

  assign alloc_fire  = en && dispatch_en && !empty && !rollback_en;
  assign alloc_valid = alloc_fire || bypass_fire;
  assign T_out       = bypass_fire ? T_old_in : entry_reg[head_idx];
  // A bypassed tag never touches the array, so it must not also be enqueued.
  assign free_fire   = en && free_en && !full && !bypass_fire;

  assign free_count   = tail_reg - head_reg;
  assign overflow_err = overflow_err_reg;

  always_comb begin
    head_next      = head_reg;
    tail_next      = tail_reg;
    ckpt_head_next = ckpt_head_reg;
    if (en && rollback_en)
      head_next = ckpt_head_reg;
    else if (alloc_fire)
      head_next = head_reg + PW'(1);
    if (free_fire)
      tail_next = tail_reg + PW'(1);
    // Rollback wins over a simultaneous checkpoint; the saved head is kept.
    if (en && checkpoint_en && !rollback_en)
      ckpt_head_next = head_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg         <= '0;
      tail_reg         <= {1'b1, {IW{1'b0}}};
      ckpt_head_reg    <= '0;
      overflow_err_reg <= 1'b0;
    end else begin
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      ckpt_head_reg <= ckpt_head_next;
      if (en && free_en && full)
        overflow_err_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FL; gi++) begin : g_entry
      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          entry_reg[gi] <= PRW'(NUM_AR + gi);
        else if (free_fire && (tail_idx == IW'(gi)))
          entry_reg[gi] <= T_old_in;
      end
    end
  endgenerate

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios then random traffic
// against a queue-style reference model using plain modulo arithmetic.
module tb_free_list;
  localparam int NUM_PR = 64;
  localparam int NUM_AR = 32;
  localparam int NUM_FL = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, dispatch_en = 1'b0, free_en = 1'b0;
  logic       checkpoint_en = 1'b0, rollback_en = 1'b0;
  logic [5:0] T_old_in = '0;
  logic [5:0] T_out;
  logic       alloc_valid, empty, full, overflow_err;
  logic [5:0] free_count;

  int tests = 0;
  int fails = 0;

  // Reference model: tags live in m_mem, m_head/m_tail are free-running counts mod 64.
  int       m_head, m_tail, m_ckpt;
  logic [5:0] m_mem [NUM_FL];
  bit       m_ovf;
  logic [5:0] last_tout;
  logic     last_av;

  free_list #(.NUM_PR(NUM_PR), .NUM_AR(NUM_AR)) dut (
    .clock(clock), .reset(reset), .en(en), .dispatch_en(dispatch_en),
    .T_out(T_out), .alloc_valid(alloc_valid), .free_en(free_en),
    .T_old_in(T_old_in), .checkpoint_en(checkpoint_en), .rollback_en(rollback_en),
    .empty(empty), .full(full), .free_count(free_count), .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_FL; i++) m_mem[i] = 6'(NUM_AR + i);
    m_head = 0; m_tail = 32; m_ckpt = 0; m_ovf = 0;
  endtask

  function automatic int m_count();
    return (m_tail - m_head + 64) % 64;
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'(m_count() == 0));
    check({tag, ".full"}, 32'(full), 32'(m_count() == NUM_FL));
    check({tag, ".free_count"}, 32'(free_count), 32'(m_count()));
    check({tag, ".overflow_err"}, 32'(overflow_err), 32'(m_ovf));
  endtask

  // One clock cycle: drive at the falling edge, check combinational outputs, advance model at the rise.
  task automatic step(input bit e, input bit d, input bit f, input logic [5:0] t,
                      input bit ck, input bit rb);
    bit   is_empty, is_full, byp, av_norm;
    logic [5:0] exp_tout;
    int   nh;
    en = e; dispatch_en = d; free_en = f; T_old_in = t;
    checkpoint_en = ck; rollback_en = rb;
    #1;
    is_empty = (m_count() == 0);
    is_full  = (m_count() == NUM_FL);
`ifdef FREE_LIST_BYPASS_EN
    byp = e && d && f && is_empty && !rb;
`else
    byp = 0;
`endif
    av_norm  = e && d && !is_empty && !rb;
    exp_tout = byp ? t : m_mem[m_head % NUM_FL];
    check("alloc_valid", 32'(alloc_valid), 32'(av_norm || byp));
    check("T_out", 32'(T_out), 32'(exp_tout));
    check_state("cyc");
    last_tout = T_out;
    last_av   = alloc_valid;
    if (e && f) begin
      if (is_full) m_ovf = 1;
      else if (!byp) begin
        m_mem[m_tail % NUM_FL] = t;
        m_tail = (m_tail + 1) % 64;
      end
    end
    nh = m_head;
    if (e && rb) nh = m_ckpt;
    else if (av_norm) nh = (m_head + 1) % 64;
    if (e && ck && !rb) m_ckpt = nh;
    m_head = nh;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reset pulse placed between clock edges; outputs must reflect reset at once.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check({tag, ".T_out"}, 32'(T_out), 32'(NUM_AR));
    check_state(tag);
    #1 reset = 1'b0;
    en = 0; dispatch_en = 0; free_en = 0; checkpoint_en = 0; rollback_en = 0;
    @(negedge clock);
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset.T_out", 32'(T_out), 32'(NUM_AR));
    check_state("reset");

    // 32 back-to-back allocates drain the list in tag order
    for (int i = 0; i < 32; i++) begin
      step(1, 1, 0, 0, 0, 0);
      check("drain.tag", 32'(last_tout), 32'(32 + i));
    end
    check("drain.count", 32'(free_count), 32'd0);
    step(1, 1, 0, 0, 0, 0);
    check("drain.refused", 32'(last_av), 32'd0);

    // refill 5, 9, 17 then allocate them back in order
    step(1, 0, 1, 6'd5, 0, 0);
    step(1, 0, 1, 6'd9, 0, 0);
    step(1, 0, 1, 6'd17, 0, 0);
    check("refill.count", 32'(free_count), 32'd3);
    step(1, 1, 0, 0, 0, 0); check("refill.t0", 32'(last_tout), 32'd5);
    step(1, 1, 0, 0, 0, 0); check("refill.t1", 32'(last_tout), 32'd9);
    step(1, 1, 0, 0, 0, 0); check("refill.t2", 32'(last_tout), 32'd17);
    check("refill.empty", 32'(empty), 32'd1);

    // checkpoint, speculative allocates, rollback with a concurrent free
    async_reset("rst1");
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 0);
      check("spec.tag", 32'(last_tout), 32'(36 + i));
    end
    step(1, 1, 1, 6'd2, 0, 1);
    check("rb.T_out", 32'(T_out), 32'd36);
    check("rb.count", 32'(free_count), 32'd29);

    // free while full: dropped, sticky overflow
    async_reset("rst2");
    step(1, 0, 1, 6'd7, 0, 0);
    check("ovf.flag", 32'(overflow_err), 32'd1);
    check("ovf.full", 32'(full), 32'd1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("ovf.sticky", 32'(overflow_err), 32'd1);

    // stall: nothing moves
    step(0, 1, 1, 6'd3, 1, 0);
    step(0, 1, 1, 6'd4, 1, 1);
    check("stall.count", 32'(free_count), 32'd31);
    async_reset("rst3");
    check("rst3.ovf", 32'(overflow_err), 32'd0);

    // empty list with simultaneous free and allocate
    for (int i = 0; i < 32; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 6'd12, 0, 0);
`ifdef FREE_LIST_BYPASS_EN
    check("byp.tag", 32'(last_tout), 32'd12);
    check("byp.valid", 32'(last_av), 32'd1);
    check("byp.count", 32'(free_count), 32'd0);
`else
    check("nobyp.valid", 32'(last_av), 32'd0);
    check("nobyp.count", 32'(free_count), 32'd1);
`endif

    // random traffic against the model
    async_reset("rst4");
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, 6'($urandom_range(0, 63)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
